// File: rtl/seq_detector_param.sv
// Serial sequence detector with a runtime-loadable N-bit pattern.
// It gives a Mealy and a Moore match flag and a saturating match counter.
module seq_detector_param #(
  parameter int               N             = 4,
  parameter logic [N-1:0]     RESET_PATTERN = 4'b1001,
  parameter bit               OVERLAP       = 1'b1,
  parameter int               CNT_W         = 8,
  localparam int              FW            = $clog2(N+1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             j,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  output logic             w_mealy,
  output logic             w,
  output logic [CNT_W-1:0] match_count,
  output logic [FW-1:0]    fill
);

  localparam logic [FW-1:0] FULL = FW'(N-1);

  logic [N-1:0] pattern;
  logic [N-2:0] hist;
  logic [N-1:0] window;
  logic         match;

  // The candidate window is the history with the current bit appended. Its low
  // N-1 bits are also the next history, so N=2 needs no special case.
  always_comb begin
    window = {hist, j};
    match  = en & ~pat_load & (fill == FULL) & (window == pattern);
  end

  assign w_mealy = match;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pattern     <= RESET_PATTERN;
      hist        <= '0;
      fill        <= '0;
      w           <= 1'b0;
      match_count <= '0;
    end else if (pat_load) begin
      pattern     <= pat_in;
      hist        <= '0;
      fill        <= '0;
      w           <= 1'b0;
      match_count <= '0;
    end else begin
      w <= match;
      if (en) begin
        if (match && !OVERLAP) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= window[N-2:0];
          fill <= (fill == FULL) ? FULL : fill + FW'(1);
        end
        if (match && (match_count != {CNT_W{1'b1}}))
          match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench: three detector variants share the serial stimulus.
// Only the instance each step targets is checked.
module tb_seq_detector_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, j = 1'b0, pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic [1:0] pat_in2 = 2'b00;

  logic       m0, w0, m1, w1, m2, w2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [2:0] f0, f1;
  logic [1:0] f2;

  int errors = 0;
  int total  = 0;

  always #5 clock = ~clock;

  seq_detector_param u0 (
    .clock(clock), .reset(reset), .en(en), .j(j), .pat_load(pat_load), .pat_in(pat_in),
    .w_mealy(m0), .w(w0), .match_count(c0), .fill(f0));

  seq_detector_param #(.OVERLAP(1'b0)) u1 (
    .clock(clock), .reset(reset), .en(en), .j(j), .pat_load(pat_load), .pat_in(pat_in),
    .w_mealy(m1), .w(w1), .match_count(c1), .fill(f1));

  seq_detector_param #(.N(2), .RESET_PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u2 (
    .clock(clock), .reset(reset), .en(en), .j(j), .pat_load(pat_load), .pat_in(pat_in2),
    .w_mealy(m2), .w(w2), .match_count(c2), .fill(f2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply a sample and settle at the falling edge, where Mealy outputs are checked.
  task automatic drive(input logic e, input logic b);
    en = e; j = b;
    @(negedge clock);
  endtask

  // Advance past the rising edge before registered outputs are checked.
  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    reset = 1'b0; #2; reset = 1'b1;
  endtask

  logic [6:0] s1  = 7'b1001001;
  logic [6:0] e1o = 7'b0001001;
  logic [6:0] e1n = 7'b0001000;

  initial begin
    tick();
    chk("reset_fill", 32'(f0), 0);
    chk("reset_w", 32'(w0), 0);
    chk("reset_cnt", 32'(c0), 0);
    reset = 1'b1;

    // 1/2: 1001001 stream, overlapping (u0) vs non-overlapping (u1)
    for (int i = 6; i >= 0; i--) begin
      drive(1'b1, s1[i]);
      chk($sformatf("t1_mealy_ov_%0d", 6-i), 32'(m0), 32'(e1o[i]));
      chk($sformatf("t2_mealy_no_%0d", 6-i), 32'(m1), 32'(e1n[i]));
      tick();
      chk($sformatf("t1_w_ov_%0d", 6-i), 32'(w0), 32'(e1o[i]));
    end
    chk("t1_cnt", 32'(c0), 2);
    chk("t2_cnt", 32'(c1), 1);
    chk("t2_fill", 32'(f1), 3);
    drive(1'b0, 1'b0);
    tick();
    chk("t1_w_drop", 32'(w0), 0);

    // 3: load 0000, then five zeros
    pat_load = 1'b1; pat_in = 4'b0000;
    drive(1'b1, 1'b0);
    chk("t3_load_mealy", 32'(m0), 0);
    tick();
    pat_load = 1'b0;
    chk("t3_load_cnt", 32'(c0), 0);
    chk("t3_load_fill", 32'(f0), 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      chk($sformatf("t3_mealy_%0d", i), 32'(m0), (i >= 3) ? 1 : 0);
      tick();
      chk($sformatf("t3_w_%0d", i), 32'(w0), (i >= 3) ? 1 : 0);
    end
    chk("t3_cnt", 32'(c0), 2);
    chk("t3_cnt_no", 32'(c1), 1);

    // 4: en gaps are ignored and force w low
    pulse_reset();
    drive(1'b1, 1'b1); tick();
    drive(1'b1, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1);
      chk($sformatf("t4_gap_mealy_%0d", i), 32'(m0), 0);
      tick();
      chk($sformatf("t4_gap_w_%0d", i), 32'(w0), 0);
      chk($sformatf("t4_gap_fill_%0d", i), 32'(f0), 2);
    end
    drive(1'b1, 1'b0);
    chk("t4_mealy_3", 32'(m0), 0);
    tick();
    drive(1'b1, 1'b1);
    chk("t4_mealy_4", 32'(m0), 1);
    tick();
    chk("t4_w", 32'(w0), 1);
    chk("t4_cnt", 32'(c0), 1);

    // 5: N=2 pattern 11, counter saturates at 3
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1);
      chk($sformatf("t5_mealy_%0d", i), 32'(m2), (i >= 1) ? 1 : 0);
      tick();
      chk($sformatf("t5_cnt_%0d", i), 32'(c2), (i >= 3) ? 3 : i);
    end

    // 6: a loaded pattern is discarded by a mid-stream reset
    pat_load = 1'b1; pat_in = 4'b0110;
    drive(1'b0, 1'b0); tick();
    pat_load = 1'b0;
    drive(1'b1, 1'b1); tick();
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    chk("t6_pre_fill", 32'(f0), 3);
    reset = 1'b0; #1;
    chk("t6_async_fill", 32'(f0), 0);
    chk("t6_async_cnt", 32'(c0), 0);
    #1; reset = 1'b1;
    drive(1'b1, 1'b1);
    chk("t6_mealy_after", 32'(m0), 0);
    tick();
    chk("t6_fill", 32'(f0), 1);
    chk("t6_cnt", 32'(c0), 0);
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b1);
    chk("t6_reset_pattern_match", 32'(m0), 1);
    tick();
    chk("t6_cnt1", 32'(c0), 1);
    // A load that coincides with a would-be match suppresses it
    drive(1'b1, 1'b0); tick();
    drive(1'b1, 1'b0); tick();
    pat_load = 1'b1; pat_in = 4'b1111;
    drive(1'b1, 1'b1);
    chk("t6_load_mealy", 32'(m0), 0);
    tick();
    pat_load = 1'b0;
    chk("t6_load_w", 32'(w0), 0);
    chk("t6_load_cnt", 32'(c0), 0);
    chk("t6_load_fill", 32'(f0), 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1);
      chk($sformatf("t6_new_mealy_%0d", i), 32'(m0), (i == 3) ? 1 : 0);
      tick();
    end
    chk("t6_new_cnt", 32'(c0), 1);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
